axi_mem_sub: RTL and testbench

AXI subordinate with a word-addressed memory that responds to the fake-CPU manager. It handles single-beat INCR transactions of 8-byte size, with independent read and write channels. It applies byte strobes and returns error responses for out-of-range or burst requests. It sits behind the interconnect as the endpoint that the CPU's self-checking reference model is validated against.

---
 rtl/axi_mem_sub.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_mem_sub.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_sub.sv
// axi_mem_sub: AXI subordinate backed by a word-addressed 64-bit memory.
// Serves single-beat INCR transactions of 8-byte size on independent read and
// write channels. Byte strobes are applied on writes. Out-of-range requests
// return DECERR. Multi-beat requests (len != 0) return SLVERR. Neither kind of
// error touches memory.
//
// Ports:
//   clk, rst              clock (posedge) and asynchronous active-high reset
//   i_axi_s_aw/awvalid    write address in        o_axi_s_awready  AW ready
//   i_axi_s_w/wvalid      write data in           o_axi_s_wready   W ready
//   o_axi_s_b/bvalid      write response out      i_axi_s_bready   B ready
//   i_axi_s_ar/arvalid    read address in         o_axi_s_arready  AR ready
//   o_axi_s_r/rvalid      read data out           i_axi_s_rready   R ready
//
// Handshake rule for every channel: a transfer happens on the rising edge
// where valid && ready. Once valid is raised it stays high, with its payload
// stable, until that edge.

package axi_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_aw_t;

    typedef axi_aw_t axi_ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
endpackage

module axi_mem_sub
    import axi_pkg::*;
#(
    parameter int          MEM_DEPTH    = 1024,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic    clk,
    input  logic    rst,
    input  axi_aw_t i_axi_s_aw,
    input  logic    i_axi_s_awvalid,
    output logic    o_axi_s_awready,
    input  axi_w_t  i_axi_s_w,
    input  logic    i_axi_s_wvalid,
    output logic    o_axi_s_wready,
    output axi_b_t  o_axi_s_b,
    output logic    o_axi_s_bvalid,
    input  logic    i_axi_s_bready,
    input  axi_ar_t i_axi_s_ar,
    input  logic    i_axi_s_arvalid,
    output logic    o_axi_s_arready,
    output axi_r_t  o_axi_s_r,
    output logic    o_axi_s_rvalid,
    input  logic    i_axi_s_rready
);
    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam int          LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'd8;

    typedef enum logic       {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [63:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t    w_state_q, w_state_d;
    logic        aw_held, w_held;
    axi_aw_t     aw_q;
    logic [63:0] w_data_q;
    logic [7:0]  w_strb_q;

    // A 33-bit difference puts the borrow of (addr < BASE_ADDR) in bit 32, so a
    // single compare against MEM_BYTES covers both out-of-range cases.
    logic [32:0]      aw_diff;
    logic             aw_oor;
    logic [IDX_W-1:0] aw_idx;
    logic [1:0]       wr_resp;
    logic             aw_hs, w_hs, commit;

    assign aw_diff = {1'b0, aw_q.addr} - {1'b0, BASE_ADDR};
    assign aw_oor  = aw_diff >= MEM_BYTES;
    assign aw_idx  = aw_diff[3 +: IDX_W];
    assign wr_resp = aw_oor ? RESP_DECERR : (aw_q.len != 8'd0) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs  = i_axi_s_awvalid && o_axi_s_awready;
    assign w_hs   = i_axi_s_wvalid && o_axi_s_wready;
    assign commit = (w_state_q == W_IDLE) && aw_held && w_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state_q <= W_IDLE;
        else     w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d       = w_state_q;
        o_axi_s_awready = 1'b0;
        o_axi_s_wready  = 1'b0;
        o_axi_s_bvalid  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                o_axi_s_awready = !aw_held;
                o_axi_s_wready  = !w_held;
                if (commit) w_state_d = W_RESP;
            end
            W_RESP: begin
                o_axi_s_bvalid = 1'b1;
                if (i_axi_s_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Non-final W beats are accepted but not stored; only the last beat of a
    // burst can ever be committed, and only when the burst is a single beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_q      <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            o_axi_s_b <= '0;
        end else begin
            if (aw_hs) begin
                aw_q    <= i_axi_s_aw;
                aw_held <= 1'b1;
            end
            if (w_hs && i_axi_s_w.last) begin
                w_data_q <= i_axi_s_w.data;
                w_strb_q <= i_axi_s_w.strb;
                w_held   <= 1'b1;
            end
            if (commit) begin
                o_axi_s_b.id   <= aw_q.id;
                o_axi_s_b.resp <= wr_resp;
                aw_held        <= 1'b0;
                w_held         <= 1'b0;
            end
        end
    end

    // Memory has no reset. A reset clears aw_held/w_held, which blocks commit.
    always_ff @(posedge clk) begin
        if (commit && wr_resp == RESP_OKAY) begin
            for (int k = 0; k < 8; k++) begin
                if (w_strb_q[k]) mem[aw_idx][8*k +: 8] <= w_data_q[8*k +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t         r_state_q, r_state_d;
    axi_ar_t          ar_q;
    logic [LAT_W-1:0] lat_cnt;
    logic [7:0]       beats_left;

    logic [32:0]      ar_diff;
    logic             ar_oor, rd_ok;
    logic [IDX_W-1:0] ar_idx;
    logic [1:0]       rd_resp;
    logic             ar_hs, r_hs;

    assign ar_diff = {1'b0, ar_q.addr} - {1'b0, BASE_ADDR};
    assign ar_oor  = ar_diff >= MEM_BYTES;
    assign ar_idx  = ar_diff[3 +: IDX_W];
    assign rd_ok   = !ar_oor && (ar_q.len == 8'd0);
    assign rd_resp = ar_oor ? RESP_DECERR : (ar_q.len != 8'd0) ? RESP_SLVERR : RESP_OKAY;

    assign ar_hs = i_axi_s_arvalid && o_axi_s_arready;
    assign r_hs  = o_axi_s_rvalid && i_axi_s_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state_q <= R_IDLE;
        else     r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d       = r_state_q;
        o_axi_s_arready = 1'b0;
        o_axi_s_rvalid  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                o_axi_s_arready = 1'b1;
                if (i_axi_s_arvalid) r_state_d = R_WAIT;
            end
            R_WAIT: begin
                if (lat_cnt == '0) r_state_d = R_DATA;
            end
            R_DATA: begin
                o_axi_s_rvalid = 1'b1;
                if (i_axi_s_rready && beats_left == 8'd0) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // beats_left counts the beats still to follow the one on the bus, so the
    // final beat is the one presented while beats_left == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q       <= '0;
            lat_cnt    <= '0;
            beats_left <= '0;
            o_axi_s_r  <= '0;
        end else begin
            if (ar_hs) begin
                ar_q    <= i_axi_s_ar;
                lat_cnt <= LAT_W'(READ_LATENCY - 1);
            end
            if (r_state_q == R_WAIT) begin
                if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end else begin
                    o_axi_s_r.id   <= ar_q.id;
                    o_axi_s_r.data <= rd_ok ? mem[ar_idx] : 64'd0;
                    o_axi_s_r.resp <= rd_resp;
                    o_axi_s_r.last <= (ar_q.len == 8'd0);
                    beats_left     <= ar_q.len;
                end
            end
            if (r_state_q == R_DATA && r_hs && beats_left != 8'd0) begin
                beats_left     <= beats_left - 8'd1;
                o_axi_s_r.last <= (beats_left == 8'd1);
            end
        end
    end

    // size/burst are not decoded; this subordinate only serves 8-byte INCR.
    logic unused_fields;
    assign unused_fields = ^{aw_q.size, aw_q.burst, ar_q.size, ar_q.burst, i_axi_s_w.id};
endmodule

// File: tb/tb_axi_mem_sub.sv
// Testbench for axi_mem_sub. Directed transactions push their hand-computed
// responses into expected queues; a monitor on the falling edge pops and
// compares every B and R handshake and checks that a stalled response stays
// put. Inputs are driven 1 time unit after the rising edge.
module tb_axi_mem_sub;
    import axi_pkg::*;

    logic    clk, rst;
    axi_aw_t aw;
    logic    awvalid, awready;
    axi_w_t  w;
    logic    wvalid, wready;
    axi_b_t  b;
    logic    bvalid, bready;
    axi_ar_t ar;
    logic    arvalid, arready;
    axi_r_t  r;
    logic    rvalid, rready;

    int checks   = 0;
    int failures = 0;
    logic rr_toggle = 1'b0;

    logic [5:0]  exp_b_q[$];   // {id, resp}
    logic [70:0] exp_r_q[$];   // {id, data, resp, last}

    axi_mem_sub #(.MEM_DEPTH(1024), .READ_LATENCY(1), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .i_axi_s_aw(aw), .i_axi_s_awvalid(awvalid), .o_axi_s_awready(awready),
        .i_axi_s_w(w), .i_axi_s_wvalid(wvalid), .o_axi_s_wready(wready),
        .o_axi_s_b(b), .o_axi_s_bvalid(bvalid), .i_axi_s_bready(bready),
        .i_axi_s_ar(ar), .i_axi_s_arvalid(arvalid), .o_axi_s_arready(arready),
        .o_axi_s_r(r), .o_axi_s_rvalid(rvalid), .i_axi_s_rready(rready)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rready = rr_toggle ? !rready : 1'b1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        aw = '{id: id, addr: addr, len: len, size: 3'd3, burst: 2'd1};
        awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!awready) check("aw_timeout", awready, 1);
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        w = '{id: 4'd0, data: data, strb: strb, last: last};
        wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wready) check("w_timeout", wready, 1);
        @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        ar = '{id: id, addr: addr, len: len, size: 3'd3, burst: 2'd1};
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!arready) check("ar_timeout", arready, 1);
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic write_single(input logic [3:0] id, input logic [31:0] addr,
                                input logic [63:0] data, input logic [7:0] strb,
                                input logic [1:0] resp);
        exp_b_q.push_back({id, resp});
        fork
            do_aw(id, addr, 8'd0);
            do_w(data, strb, 1'b1);
        join
    endtask

    task automatic read_single(input logic [3:0] id, input logic [31:0] addr,
                               input logic [63:0] data, input logic [1:0] resp);
        exp_r_q.push_back({id, data, resp, 1'b1});
        do_ar(id, addr, 8'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_b", 32'(exp_b_q.size()), 0);
        check("drain_r", 32'(exp_r_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, awready, 1);
        check({tag, "_wready"}, wready, 1);
        check({tag, "_arready"}, arready, 1);
        check({tag, "_bvalid"}, bvalid, 0);
        check({tag, "_rvalid"}, rvalid, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic        b_stall, r_stall;
        logic [5:0]  prev_b, eb;
        logic [70:0] prev_r, er;
        b_stall = 1'b0;
        r_stall = 1'b0;
        prev_b  = '0;
        prev_r  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                b_stall = 1'b0;
                r_stall = 1'b0;
            end else begin
                if (b_stall) begin
                    check("b_hold_valid", bvalid, 1);
                    check("b_hold_data", b, prev_b);
                end
                if (r_stall) begin
                    check("r_hold_valid", rvalid, 1);
                    check("r_hold_data", r, prev_r);
                end
                if (bvalid && bready) begin
                    if (exp_b_q.size() == 0) check("b_unexpected", bvalid, 0);
                    else begin
                        eb = exp_b_q.pop_front();
                        check("b_beat", b, eb);
                    end
                end
                if (rvalid && rready) begin
                    if (exp_r_q.size() == 0) check("r_unexpected", rvalid, 0);
                    else begin
                        er = exp_r_q.pop_front();
                        check("r_beat", r, er);
                    end
                end
                b_stall = bvalid && !bready;
                r_stall = rvalid && !rready;
                prev_b  = b;
                prev_r  = r;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1;
        aw = '0; awvalid = 1'b0;
        w = '0;  wvalid = 1'b0;
        ar = '0; arvalid = 1'b0;
        bready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");
        check("reset_b", b, 0);
        check("reset_r", r, 0);

        // Basic write, W three cycles after AW, then read back with latency check.
        exp_b_q.push_back({4'd3, 2'd0});
        do_aw(4'd3, 32'h40, 8'd0);
        repeat (3) @(posedge clk);
        #1 do_w(64'h1122334455667788, 8'hFF, 1'b1);
        wait_idle();
        read_single(4'd5, 32'h40, 64'h1122334455667788, 2'd0);
        check("rlat_wait", rvalid, 0);
        @(posedge clk);
        #1 check("rlat_data", rvalid, 1);
        wait_idle();

        // AW+W same cycle, then W before AW with a partial strobe.
        write_single(4'd1, 32'h80, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'd0);
        wait_idle();
        exp_b_q.push_back({4'd2, 2'd0});
        do_w(64'h0, 8'h0F, 1'b1);
        @(posedge clk);
        #1 do_aw(4'd2, 32'h80, 8'd0);
        wait_idle();
        read_single(4'd6, 32'h80, 64'hFFFFFFFF00000000, 2'd0);
        wait_idle();

        // B held off for 5 cycles; monitor checks stability each cycle.
        bready = 1'b0;
        write_single(4'd7, 32'h100, 64'h0123456789ABCDEF, 8'hFF, 2'd0);
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bstall_bvalid", bvalid, 1);
        repeat (5) @(posedge clk);
        #1 bready = 1'b1;
        wait_idle();
        read_single(4'd7, 32'h100, 64'h0123456789ABCDEF, 2'd0);
        wait_idle();

        // Out of range: 0x2000 aliases index 0, which must stay untouched.
        write_single(4'd4, 32'h0, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 2'd0);
        wait_idle();
        write_single(4'd6, 32'h2000, 64'hDEADBEEFDEADBEEF, 8'hFF, 2'd3);
        wait_idle();
        read_single(4'd8, 32'h2000, 64'h0, 2'd3);
        wait_idle();
        read_single(4'd4, 32'h0, 64'hA5A5A5A5A5A5A5A5, 2'd0);
        wait_idle();

        // Burst read: 4 SLVERR beats with zero data, rready toggling.
        for (int k = 0; k < 4; k++) exp_r_q.push_back({4'd9, 64'h0, 2'd2, (k == 3)});
        rr_toggle = 1'b1;
        do_ar(4'd9, 32'h40, 8'd3);
        wait_idle();
        rr_toggle = 1'b0;
        @(posedge clk);
        #1;

        // Burst write: 2 W beats, SLVERR, memory at 0x40 unchanged.
        exp_b_q.push_back({4'd10, 2'd2});
        fork
            do_aw(4'd10, 32'h40, 8'd1);
            begin
                do_w(64'h0, 8'hFF, 1'b0);
                do_w(64'h0, 8'hFF, 1'b1);
            end
        join
        wait_idle();
        read_single(4'd11, 32'h40, 64'h1122334455667788, 2'd0);
        wait_idle();

        // Reset while in W_RESP: write is committed, B is dropped.
        bready = 1'b0;
        fork
            do_aw(4'd12, 32'hC0, 8'd0);
            do_w(64'hCAFEF00D12345678, 8'hFF, 1'b1);
        join
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wresp_bvalid", bvalid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_idle_outputs("rst_wresp");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bready = 1'b1;

        // Reset while in R_WAIT: no R beat may follow.
        do_ar(4'd13, 32'h40, 8'd0);
        rst = 1'b1;
        #1 check_idle_outputs("rst_rwait");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("post_rst_rvalid", rvalid, 0);

        read_single(4'd14, 32'hC0, 64'hCAFEF00D12345678, 2'd0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
